// File: rtl/ifetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, redirect kinds,
// default fetch addresses and the branch offset helper.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_SEQ    = 2'b00,
        KIND_BRANCH = 2'b01,
        KIND_JUMP   = 2'b10,
        KIND_JREG   = 2'b11
    } redirect_kind_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEFAULT  = 32'h0000_0080;

    // Word offset of a branch, sign-extended and scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational selection of the next fetch target for the held instruction.
// Alignment policy is applied by the caller, not here.
module next_pc_calc
    import ifetch_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic [1:0]  i_kind,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_index26,
    input  logic [31:0] i_reg,
    output logic [31:0] o_target
);

    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    assign w_branch_target = i_pc_plus4 + branch_offset(i_imm16);
    assign w_jump_target   = {i_pc_plus4[31:28], i_index26, 2'b00};

    always_comb begin
        o_target = i_pc_plus4;
        case (i_kind)
            KIND_SEQ:    o_target = i_pc_plus4;
            KIND_BRANCH: o_target = w_branch_target;
            KIND_JUMP:   o_target = w_jump_target;
            KIND_JREG:   o_target = i_reg;
            default:     o_target = i_pc_plus4;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, ready-qualified instruction memory handshake and
// valid/ready hand-off to decode. Optional misaligned-target trap under
// IFETCH_MISALIGN_TRAP_EN (adds misalign/bad_addr ports).
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_PC  = TRAP_PC_DEFAULT
`endif
)
(
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  redirect_kind,
    input  logic [15:0] redirect_imm16,
    input  logic [25:0] redirect_index26,
    input  logic [31:0] redirect_reg
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign,
    output logic [31:0] bad_addr
`endif
);

    state_t      r_state;
    logic [31:0] r_imem_addr;
    logic [31:0] r_instruction;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic [31:0] w_target;
    logic [31:0] w_next_addr;
    logic        w_handshake;

    next_pc_calc u_next_pc_calc (
        .i_pc_plus4 (r_pc_plus4),
        .i_kind     (redirect_kind),
        .i_imm16    (redirect_imm16),
        .i_index26  (redirect_index26),
        .i_reg      (redirect_reg),
        .o_target   (w_target)
    );

    assign w_handshake = (r_state == ST_HOLD) && instr_ready;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        r_misalign;
    logic [31:0] r_bad_addr;
    logic        w_misaligned;

    assign w_misaligned = |w_target[1:0];
    assign w_next_addr  = w_misaligned ? TRAP_PC : w_target;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
            r_bad_addr <= 32'h0000_0000;
        end else if (w_handshake && w_misaligned) begin
            r_misalign <= 1'b1;
            r_bad_addr <= w_target;
        end
    end

    assign misalign = r_misalign;
    assign bad_addr = r_bad_addr;
`else
    // Low address bits are dropped so fetches always stay word aligned.
    assign w_next_addr = w_target & ~32'h0000_0003;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_imem_addr   <= RESET_PC;
            r_instruction <= 32'h0000_0000;
            r_pc          <= RESET_PC;
            r_pc_plus4    <= RESET_PC + 32'd4;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instruction <= imem_rdata;
                        r_pc          <= r_imem_addr;
                        r_pc_plus4    <= r_imem_addr + 32'd4;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_imem_addr <= w_next_addr;
                        r_state     <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign instr_valid = (r_state == ST_HOLD);
    assign imem_addr   = r_imem_addr;
    assign instruction = r_instruction;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc_plus4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed corner cases followed by
// randomized redirects, memory latency and decode stalls against a plain model.
module tb_instruction_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_TRAP_PC  = 32'h0000_0080;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  redirect_kind = 2'b00;
    logic [15:0] redirect_imm16 = 16'h0;
    logic [25:0] redirect_index26 = 26'h0;
    logic [31:0] redirect_reg = 32'h0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] bad_addr;
`endif

    instruction_fetch dut (
        .clock            (clock),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .instruction      (instruction),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .redirect_kind    (redirect_kind),
        .redirect_imm16   (redirect_imm16),
        .redirect_index26 (redirect_index26),
        .redirect_reg     (redirect_reg)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .misalign         (misalign),
        .bad_addr         (bad_addr)
`endif
    );

    always #5 clock = ~clock;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_mis  = 1'b0;
    logic [31:0] exp_bad  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Architectural next-address rule, in plain arithmetic on the held PC.
    function automatic logic [31:0] model_target(input logic [31:0] cur_pc, input logic [1:0] kind,
                                                 input logic [15:0] imm, input logic [25:0] idx,
                                                 input logic [31:0] rg);
        logic [31:0] seq;
        int          off;
        seq = cur_pc + 32'd4;
        off = int'($signed(imm));
        case (kind)
            2'd0:    return seq;
            2'd1:    return seq + 32'(off * 4);
            2'd2:    return (seq & 32'hF000_0000) + 32'(idx) * 32'd4;
            default: return rg;
        endcase
    endfunction

    task automatic fetch_step(input int delay);
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clock);
        chk_bit("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, exp_addr);
        chk_bit("fetch_valid_low", instr_valid, 1'b0);
        for (int i = 0; i < delay; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(negedge clock);
            chk_bit("wait_req", imem_req, 1'b1);
            chk("wait_addr_stable", imem_addr, exp_addr);
        end
        exp_instr  = $urandom;
        imem_rdata = exp_instr;
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        exp_pc     = exp_addr;
        chk_bit("hold_valid", instr_valid, 1'b1);
        chk("hold_instr", instruction, exp_instr);
        chk("hold_pc", pc, exp_pc);
        chk("hold_pc_plus4", pc_plus4, exp_pc + 32'd4);
        chk_bit("hold_req_low", imem_req, 1'b0);
        $display("instr pc=%08h word=%08h mem_delay=%0d", exp_pc, exp_instr, delay);
    endtask

    task automatic hold_step(input int stall, input logic [1:0] kind, input logic [15:0] imm,
                             input logic [25:0] idx, input logic [31:0] rg);
        logic [31:0] t;
        for (int i = 0; i < stall; i++) begin
            instr_ready      = 1'b0;
            redirect_kind    = 2'($urandom_range(0, 3));
            redirect_imm16   = 16'($urandom);
            redirect_index26 = 26'($urandom);
            redirect_reg     = $urandom;
            imem_ready       = 1'($urandom_range(0, 1));
            imem_rdata       = $urandom;
            @(negedge clock);
            imem_ready = 1'b0;
            chk_bit("stall_valid", instr_valid, 1'b1);
            chk("stall_instr", instruction, exp_instr);
            chk("stall_pc", pc, exp_pc);
            chk_bit("stall_req_low", imem_req, 1'b0);
        end
        redirect_kind    = kind;
        redirect_imm16   = imm;
        redirect_index26 = idx;
        redirect_reg     = rg;
        instr_ready      = 1'b1;
        @(negedge clock);
        instr_ready      = 1'b0;
        redirect_kind    = 2'($urandom_range(0, 3));
        redirect_reg     = $urandom;
        t = model_target(exp_pc, kind, imm, idx, rg);
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) begin
            exp_mis  = 1'b1;
            exp_bad  = t;
            exp_addr = TB_TRAP_PC;
        end else begin
            exp_addr = t;
        end
`else
        exp_addr = t & 32'hFFFF_FFFC;
`endif
        chk_bit("accept_valid_low", instr_valid, 1'b0);
        chk_bit("accept_req", imem_req, 1'b1);
        chk("next_addr", imem_addr, exp_addr);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk_bit("misalign", misalign, exp_mis);
        chk("bad_addr", bad_addr, exp_bad);
`endif
        $display("accept pc=%08h kind=%0d stall=%0d next=%08h", exp_pc, kind, stall, exp_addr);
    endtask

    initial begin
        logic [31:0] rg;
        repeat (2) @(negedge clock);
        chk_bit("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, TB_RESET_PC);
        chk("rst_instr", instruction, 32'h0);
        chk_bit("rst_valid", instr_valid, 1'b0);
        chk("rst_pc", pc, TB_RESET_PC);
        chk("rst_pc_plus4", pc_plus4, TB_RESET_PC + 32'd4);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk_bit("rst_misalign", misalign, 1'b0);
        chk("rst_bad_addr", bad_addr, 32'h0);
`endif
        reset = 1'b0;
        exp_addr = TB_RESET_PC;
        @(negedge clock);

        // Sequential stream 0, 4, 8 with immediate ready/accept.
        fetch_step(0); hold_step(0, 2'd0, 16'h0, 26'h0, 32'h0);
        chk("seq_4", imem_addr, 32'h4);
        fetch_step(0); hold_step(0, 2'd0, 16'h0, 26'h0, 32'h0);
        chk("seq_8", imem_addr, 32'h8);
        fetch_step(0);
        hold_step(5, 2'd3, 16'h0, 26'h0, 32'h0000_0100);
        fetch_step(3);
        hold_step(0, 2'd1, 16'hFFFF, 26'h0, 32'h0);
        chk("branch_back", imem_addr, 32'h0000_0100);
        fetch_step(1);
        hold_step(0, 2'd3, 16'h0, 26'h0, 32'h1000_0000);
        fetch_step(0);
        hold_step(2, 2'd2, 16'h0, 26'h40, 32'h0);
        chk("jump_target", imem_addr, 32'h1000_0100);
        fetch_step(0);
        hold_step(0, 2'd3, 16'h0, 26'h0, 32'hFFFF_FFFC);
        fetch_step(0);
        hold_step(0, 2'd0, 16'h0, 26'h0, 32'h0);
        chk("wrap_zero", imem_addr, 32'h0);
        fetch_step(0);
        hold_step(1, 2'd3, 16'h0, 26'h0, 32'h0000_0202);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("misalign_trap_addr", imem_addr, 32'h0000_0080);
`else
        chk("misalign_forced", imem_addr, 32'h0000_0200);
`endif
        fetch_step(2);

        for (int n = 0; n < 40; n++) begin
            rg = $urandom;
            if ($urandom_range(0, 3) != 0) rg = rg & 32'hFFFF_FFFC;
            hold_step($urandom_range(0, 3), 2'($urandom_range(0, 3)), 16'($urandom),
                      26'($urandom), rg);
            fetch_step($urandom_range(0, 3));
        end

        // Reset while holding discards the instruction.
        #2 reset = 1'b1;
        #1;
        chk_bit("rst_hold_valid", instr_valid, 1'b0);
        chk("rst_hold_instr", instruction, 32'h0);
        chk("rst_hold_pc", pc, TB_RESET_PC);
        exp_mis = 1'b0;
        exp_bad = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        exp_addr = TB_RESET_PC;
        @(negedge clock);
        fetch_step(1);
        hold_step(0, 2'd0, 16'h0, 26'h0, 32'h0);

        // Reset mid-fetch drops the request without waiting for a clock.
        #2 reset = 1'b1;
        #1;
        chk_bit("rst_fetch_req", imem_req, 1'b0);
        chk("rst_fetch_addr", imem_addr, TB_RESET_PC);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
